gb_frame_capture: RTL and testbench
===================================

Name: gb_frame_capture

Overview:
- Parametrised successor to the Game Boy LCD-to-BRAM write path in the HDMI converter.
- Captures pixels from the Game Boy LCD strobe interface into a linear framebuffer of NUM_BUFFERS frames, with vsync-aligned frame start and tear-free double-buffer swap.
- Adds a selectable line-advance mode, framebuffer clear on request, and sticky error reporting.
- Sits in the Game Boy clock domain. It drives BRAM port A; the pixel-clock reader uses rd_buf to pick the frame to display.

Parameters:
H_PIXELS, 160, active pixels per line
V_LINES, 144, active lines per frame
PIX_BITS, 2, bits per pixel
NUM_BUFFERS, 2, frames in memory (1 or 2); 1 disables swapping
LINE_MODE, 0, 0 = advance line after H_PIXELS pixels; 1 = advance line on gb_hs rising edge
ADDR_BITS, $clog2(NUM_BUFFERS*H_PIXELS*V_LINES), write address width

Ports:
clk  in  1  Game Boy clock
reset  in  1  synchronous, active-high reset
gb_hs  in  1  horizontal sync
gb_vs  in  1  vertical sync
gb_cpl  in  1  pixel latch
gb_valid  in  1  pixel valid
gb_pixel  in  PIX_BITS  pixel data
clear_req  in  1  one-cycle request to refill all buffers
clear_value  in  PIX_BITS  fill value for clear
err_clr  in  1  clears sticky error flags
wr_addr  out  ADDR_BITS  BRAM write address
wr_data  out  PIX_BITS  BRAM write data
wr_we  out  1  BRAM write enable
rd_buf  out  1  buffer index the display side reads
frame_done  out  1  one-cycle pulse on each completed frame
busy  out  1  high while clearing
err_overrun  out  1  sticky: pixel dropped (line or frame overfull)
err_short  out  1  sticky: vsync arrived before V_LINES lines completed

Behaviour:
- Reset values: wr_we=0, wr_addr=0, wr_data=0, rd_buf=0, frame_done=0, err_*=0, busy=1. State is CLEAR with clear address 0, write buffer wbuf = (NUM_BUFFERS==2), x=0, y=0.
- Strobe: s = gb_valid & gb_cpl. A pixel event occurs in cycle n when s_n=1 and the registered s_{n-1}=0. In cycle n+1: wr_we=1, wr_data=gb_pixel sampled at n, wr_addr = wbuf*H_PIXELS*V_LINES + y*H_PIXELS + x. Latency is 1 cycle. A continuously high s produces one write only.
- Edges of gb_hs and gb_vs are detected against their registered copies in the same way.
- States:
  - CLEAR: wr_we=1 every cycle; addresses 0..NUM_BUFFERS*H_PIXELS*V_LINES-1 are written with clear_value. After the last address: busy=0, go to WAIT_VS. Pixel and sync events are ignored.
  - WAIT_VS: no writes. On gb_vs rise: x=0, y=0, go to CAPTURE.
  - CAPTURE: pixel event writes at (x,y), then x++.
    - LINE_MODE=0: when x==H_PIXELS-1, x wraps to 0 and y++.
    - LINE_MODE=1: when x==H_PIXELS, the pixel is dropped and err_overrun is set. On gb_hs rise with x!=0, x=0 and y++. An hs rise with x==0 is ignored.
- Pixel event with y==V_LINES: dropped, no write, err_overrun=1.
- gb_vs rise in CAPTURE:
  - If y==V_LINES: frame_done pulses the next cycle. With NUM_BUFFERS==2, rd_buf<=wbuf and wbuf<=~wbuf in the same cycle.
  - Otherwise: err_short=1, no swap, no frame_done.
  - In both cases x=0, y=0 and the state stays CAPTURE.
- NUM_BUFFERS==1: wbuf=rd_buf=0 always. frame_done still pulses on complete frames.
- Simultaneous vsync rise and pixel event: the vsync update (swap, x,y reset) takes effect first. The pixel is written at (0,0) of the new write buffer, and x becomes 1.
- Simultaneous hs rise and pixel event (LINE_MODE=1): the line advance takes effect first. The pixel is written at x=0 of the new line.
- clear_req in any state: the next cycle enters CLEAR at address 0 with busy=1. x, y, wbuf and rd_buf are kept. A clear_req during CLEAR restarts it at address 0.
- err_clr clears both flags. A set event in the same cycle wins.
- reset mid-operation: all state returns to reset values and CLEAR restarts.

Test Plan:
- Reset with H=160, V=144, NUM_BUFFERS=2 -> busy=1 for 46080 cycles, wr_addr counts 0..46079 with wr_data=clear_value, then busy=0 and wr_we=0.
- vs rise, then 160*144 strobe pulses, then vs rise (LINE_MODE=0) -> first write at addr 23040 (wbuf=1), last at 46079; frame_done pulses once; rd_buf 0->1; the next frame's first write goes to addr 0.
- s held high for 5 cycles -> exactly one wr_we pulse, 1 cycle after the rising edge, with data sampled at the edge.
- LINE_MODE=1: 162 pixels then hs rise -> two drops, err_overrun=1, next pixel at addr base+160; assert err_clr -> err_overrun=0.
- vs rise after 100 lines -> err_short=1, no frame_done, rd_buf unchanged, next write at addr base+0.
- clear_req at pixel 500 of a frame -> busy=1 the next cycle, clear from addr 0, pixel events ignored until busy=0, then the block waits for vs rise before capturing.

Source files
------------

// File: rtl/gb_frame_capture_if.sv
// Buses around the Game Boy frame capture block: LCD strobe input and BRAM
// port-A write side. The capture block is the LCD slave and the BRAM master.
interface gb_lcd_if #(
  parameter int PIX_BITS = 2
);
  logic                gb_hs;
  logic                gb_vs;
  logic                gb_cpl;
  logic                gb_valid;
  logic [PIX_BITS-1:0] gb_pixel;

  modport master (output gb_hs, gb_vs, gb_cpl, gb_valid, gb_pixel);
  modport slave  (input  gb_hs, gb_vs, gb_cpl, gb_valid, gb_pixel);
endinterface

interface gb_wr_if #(
  parameter int PIX_BITS  = 2,
  parameter int ADDR_BITS = 16
);
  logic [ADDR_BITS-1:0] wr_addr;
  logic [PIX_BITS-1:0]  wr_data;
  logic                 wr_we;

  modport master (output wr_addr, wr_data, wr_we);
  modport slave  (input  wr_addr, wr_data, wr_we);
endinterface

// File: rtl/gb_frame_capture.sv
// Game Boy LCD capture into a linear NUM_BUFFERS-frame BRAM image with
// vsync-aligned start, tear-free buffer swap, clear on request and sticky errors.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_CLEAR   | fill every buffer with clear_value, one address per cycle
// S_WAIT_VS | idle until the first vsync rise after a clear
// S_CAPTURE | write pixels at (x,y) of the write buffer, swap on full frame
module gb_frame_capture #(
  parameter int H_PIXELS    = 160,
  parameter int V_LINES     = 144,
  parameter int PIX_BITS    = 2,
  parameter int NUM_BUFFERS = 2,
  parameter int LINE_MODE   = 0,
  parameter int ADDR_BITS   = $clog2(NUM_BUFFERS*H_PIXELS*V_LINES)
) (
  input  logic                clk,
  input  logic                reset,
  gb_lcd_if.slave             lcd,
  gb_wr_if.master             wr,
  input  logic                clear_req,
  input  logic [PIX_BITS-1:0] clear_value,
  input  logic                err_clr,
  output logic                rd_buf,
  output logic                frame_done,
  output logic                busy,
  output logic                err_overrun,
  output logic                err_short
);
  localparam int FRAME = H_PIXELS*V_LINES;
  localparam int TOTAL = NUM_BUFFERS*FRAME;
  localparam int XW    = $clog2(H_PIXELS+1);
  localparam int YW    = $clog2(V_LINES+1);
  localparam logic                 DUAL   = (NUM_BUFFERS == 2);
  localparam logic [ADDR_BITS-1:0] LAST_A = ADDR_BITS'(TOTAL-1);
  localparam logic [ADDR_BITS-1:0] BUF1_A = DUAL ? ADDR_BITS'(FRAME) : '0;
  localparam logic [ADDR_BITS-1:0] H_A    = ADDR_BITS'(H_PIXELS);
  localparam logic [XW-1:0]        H_X    = XW'(H_PIXELS);
  localparam logic [XW-1:0]        H_LAST = XW'(H_PIXELS-1);
  localparam logic [YW-1:0]        V_Y    = YW'(V_LINES);

  typedef enum logic [1:0] {S_CLEAR, S_WAIT_VS, S_CAPTURE} state_t;

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] clr_addr_q, clr_addr_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic                 wbuf_q, wbuf_d;
  logic                 rd_buf_q, rd_buf_d;
  logic                 wr_we_q, wr_we_d;
  logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_BITS-1:0]  wr_data_q, wr_data_d;
  logic                 frame_done_q, frame_done_d;
  logic                 ovr_q, ovr_d;
  logic                 short_q, short_d;
  logic                 s_q, hs_q, vs_q;
  logic                 s, pix_ev, hs_rise, vs_rise;
  logic                 set_ovr, set_short;

  assign s       = lcd.gb_valid & lcd.gb_cpl;
  assign pix_ev  = s & ~s_q;
  assign hs_rise = lcd.gb_hs & ~hs_q;
  assign vs_rise = lcd.gb_vs & ~vs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_addr_q   <= '0;
      x_q          <= '0;
      y_q          <= '0;
      wbuf_q       <= DUAL;
      rd_buf_q     <= 1'b0;
      wr_we_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      ovr_q        <= 1'b0;
      short_q      <= 1'b0;
      s_q          <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      x_q          <= x_d;
      y_q          <= y_d;
      wbuf_q       <= wbuf_d;
      rd_buf_q     <= rd_buf_d;
      wr_we_q      <= wr_we_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      ovr_q        <= ovr_d;
      short_q      <= short_d;
      s_q          <= s;
      hs_q         <= lcd.gb_hs;
      vs_q         <= lcd.gb_vs;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR:   if (clr_addr_q == LAST_A) state_d = S_WAIT_VS;
      S_WAIT_VS: if (vs_rise) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_CAPTURE;
      default:   state_d = S_CLEAR;
    endcase
    if (clear_req) state_d = S_CLEAR;
  end

  // x_d/y_d/wbuf_d are updated in order so a same-cycle sync event is seen
  // by the pixel that arrives with it.
  always_comb begin
    clr_addr_d   = clr_addr_q;
    x_d          = x_q;
    y_d          = y_q;
    wbuf_d       = wbuf_q;
    rd_buf_d     = rd_buf_q;
    wr_we_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    set_ovr      = 1'b0;
    set_short    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        wr_we_d   = 1'b1;
        wr_addr_d = clr_addr_q;
        wr_data_d = clear_value;
        if (clr_addr_q != LAST_A) clr_addr_d = clr_addr_q + 1'b1;
      end
      S_WAIT_VS: begin
        if (vs_rise) begin
          x_d = '0;
          y_d = '0;
        end
      end
      S_CAPTURE: begin
        if (vs_rise) begin
          if (y_q == V_Y) begin
            frame_done_d = 1'b1;
            if (DUAL) begin
              rd_buf_d = wbuf_q;
              wbuf_d   = ~wbuf_q;
            end
          end else begin
            set_short = 1'b1;
          end
          x_d = '0;
          y_d = '0;
        end else if (LINE_MODE == 1 && hs_rise && x_q != '0) begin
          x_d = '0;
          y_d = y_q + 1'b1;
        end
        if (pix_ev) begin
          if (y_d == V_Y || (LINE_MODE == 1 && x_d == H_X)) begin
            set_ovr = 1'b1;
          end else begin
            wr_we_d   = 1'b1;
            wr_addr_d = (wbuf_d ? BUF1_A : '0) + ADDR_BITS'(y_d) * H_A + ADDR_BITS'(x_d);
            wr_data_d = lcd.gb_pixel;
            if (LINE_MODE == 0 && x_d == H_LAST) begin
              x_d = '0;
              y_d = y_d + 1'b1;
            end else begin
              x_d = x_d + 1'b1;
            end
          end
        end
      end
      default: ;
    endcase
    if (clear_req) clr_addr_d = '0;
    ovr_d   = (ovr_q & ~err_clr) | set_ovr;
    short_d = (short_q & ~err_clr) | set_short;
  end

  assign busy        = (state_q == S_CLEAR);
  assign wr.wr_we    = wr_we_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign rd_buf      = rd_buf_q;
  assign frame_done  = frame_done_q;
  assign err_overrun = ovr_q;
  assign err_short   = short_q;
endmodule

// File: tb/tb_gb_frame_capture.sv
// Bench for gb_frame_capture: a double-buffered line-count instance and a
// single-buffer hsync-advance instance, checked every cycle against a model.
module tb_gb_frame_capture;
  localparam int HX  = 8;
  localparam int VA  = 6;
  localparam int VB  = 4;
  localparam int AWA = $clog2(2*HX*VA);
  localparam int AWB = $clog2(HX*VB);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gb_lcd_if #(.PIX_BITS(2)) lcd_a ();
  gb_lcd_if #(.PIX_BITS(2)) lcd_b ();
  gb_wr_if #(.PIX_BITS(2), .ADDR_BITS(AWA)) wr_a ();
  gb_wr_if #(.PIX_BITS(2), .ADDR_BITS(AWB)) wr_b ();
  logic       clr_req_a, clr_req_b, err_clr_a, err_clr_b;
  logic [1:0] clr_val_a, clr_val_b;
  logic       rd_a, rd_b, fd_a, fd_b, busy_a, busy_b, ovr_a, ovr_b, sht_a, sht_b;

  gb_frame_capture #(.H_PIXELS(HX), .V_LINES(VA), .PIX_BITS(2), .NUM_BUFFERS(2), .LINE_MODE(0)) dut_a (
    .clk(clk), .reset(reset), .lcd(lcd_a), .wr(wr_a), .clear_req(clr_req_a),
    .clear_value(clr_val_a), .err_clr(err_clr_a), .rd_buf(rd_a), .frame_done(fd_a),
    .busy(busy_a), .err_overrun(ovr_a), .err_short(sht_a));

  gb_frame_capture #(.H_PIXELS(HX), .V_LINES(VB), .PIX_BITS(2), .NUM_BUFFERS(1), .LINE_MODE(1)) dut_b (
    .clk(clk), .reset(reset), .lcd(lcd_b), .wr(wr_b), .clear_req(clr_req_b),
    .clear_value(clr_val_b), .err_clr(err_clr_b), .rd_buf(rd_b), .frame_done(fd_b),
    .busy(busy_b), .err_overrun(ovr_b), .err_short(sht_b));

  int checks = 0;
  int failures = 0;

  // reference model: mode 0 clearing, 1 waiting for vsync, 2 capturing
  int m_mode[2], m_clr[2], m_x[2], m_y[2], m_wbuf[2], m_rd[2];
  bit m_ovr[2], m_sht[2];
  bit p_s[2], p_hs[2], p_vs[2];
  bit c_s[2], c_hs[2], c_vs[2], c_creq[2], c_eclr[2];
  logic [1:0] c_pix[2], c_cval[2];
  bit e_we[2], e_fd[2];
  int e_addr[2], e_data[2];

  function automatic int vl(int d); return (d == 0) ? VA : VB; endfunction
  function automatic int nb(int d); return (d == 0) ? 2 : 1; endfunction
  function automatic bit lm(int d); return (d != 0); endfunction

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s dut=%0d observed=%0d expected=%0d", tag, d, obs, want);
    end
  endtask

  task automatic model_reset(int d);
    m_mode[d] = 0; m_clr[d] = 0; m_x[d] = 0; m_y[d] = 0;
    m_wbuf[d] = (nb(d) == 2) ? 1 : 0; m_rd[d] = 0;
    m_ovr[d] = 0; m_sht[d] = 0;
    p_s[d] = 0; p_hs[d] = 0; p_vs[d] = 0;
    e_we[d] = 0; e_fd[d] = 0;
  endtask

  task automatic model_step(int d);
    bit pe, hr, vr, so, ss;
    pe = c_s[d] && !p_s[d];
    hr = c_hs[d] && !p_hs[d];
    vr = c_vs[d] && !p_vs[d];
    e_we[d] = 0; e_fd[d] = 0; so = 0; ss = 0;
    case (m_mode[d])
      0: begin
        e_we[d] = 1; e_addr[d] = m_clr[d]; e_data[d] = c_cval[d];
        if (m_clr[d] == nb(d)*HX*vl(d) - 1) m_mode[d] = 1;
        else m_clr[d]++;
      end
      1: if (vr) begin m_x[d] = 0; m_y[d] = 0; m_mode[d] = 2; end
      default: begin
        if (vr) begin
          if (m_y[d] == vl(d)) begin
            e_fd[d] = 1;
            if (nb(d) == 2) begin m_rd[d] = m_wbuf[d]; m_wbuf[d] = 1 - m_wbuf[d]; end
          end else ss = 1;
          m_x[d] = 0; m_y[d] = 0;
        end else if (lm(d) && hr && m_x[d] != 0) begin
          m_x[d] = 0; m_y[d]++;
        end
        if (pe) begin
          if (m_y[d] == vl(d) || (lm(d) && m_x[d] == HX)) so = 1;
          else begin
            e_we[d] = 1;
            e_addr[d] = m_wbuf[d]*HX*vl(d) + m_y[d]*HX + m_x[d];
            e_data[d] = c_pix[d];
            m_x[d]++;
            if (!lm(d) && m_x[d] == HX) begin m_x[d] = 0; m_y[d]++; end
          end
        end
      end
    endcase
    if (c_creq[d]) begin m_mode[d] = 0; m_clr[d] = 0; end
    m_ovr[d] = (m_ovr[d] && !c_eclr[d]) || so;
    m_sht[d] = (m_sht[d] && !c_eclr[d]) || ss;
  endtask

  task automatic drive(int d);
    logic v, c;
    if (c_s[d]) begin v = 1; c = 1; end
    else begin
      case ($urandom_range(0, 2))
        0:       begin v = 0; c = 0; end
        1:       begin v = 1; c = 0; end
        default: begin v = 0; c = 1; end
      endcase
    end
    if (d == 0) begin
      lcd_a.gb_hs = c_hs[0]; lcd_a.gb_vs = c_vs[0]; lcd_a.gb_valid = v; lcd_a.gb_cpl = c;
      lcd_a.gb_pixel = c_pix[0]; clr_req_a = c_creq[0]; clr_val_a = c_cval[0]; err_clr_a = c_eclr[0];
    end else begin
      lcd_b.gb_hs = c_hs[1]; lcd_b.gb_vs = c_vs[1]; lcd_b.gb_valid = v; lcd_b.gb_cpl = c;
      lcd_b.gb_pixel = c_pix[1]; clr_req_b = c_creq[1]; clr_val_b = c_cval[1]; err_clr_b = c_eclr[1];
    end
  endtask

  task automatic check(int d);
    logic [31:0] we, addr, data, fd, rd, bz, ov, sh;
    if (d == 0) begin
      we = 32'(wr_a.wr_we); addr = 32'(wr_a.wr_addr); data = 32'(wr_a.wr_data);
      fd = 32'(fd_a); rd = 32'(rd_a); bz = 32'(busy_a); ov = 32'(ovr_a); sh = 32'(sht_a);
    end else begin
      we = 32'(wr_b.wr_we); addr = 32'(wr_b.wr_addr); data = 32'(wr_b.wr_data);
      fd = 32'(fd_b); rd = 32'(rd_b); bz = 32'(busy_b); ov = 32'(ovr_b); sh = 32'(sht_b);
    end
    chk("wr_we", d, we, 32'(e_we[d]));
    if (e_we[d]) begin
      chk("wr_addr", d, addr, e_addr[d]);
      chk("wr_data", d, data, e_data[d]);
    end
    chk("frame_done", d, fd, 32'(e_fd[d]));
    chk("rd_buf", d, rd, m_rd[d]);
    chk("busy", d, bz, (m_mode[d] == 0) ? 1 : 0);
    chk("err_overrun", d, ov, 32'(m_ovr[d]));
    chk("err_short", d, sh, 32'(m_sht[d]));
  endtask

  task automatic tick();
    for (int d = 0; d < 2; d++) begin drive(d); model_step(d); end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check(d);
      p_s[d] = c_s[d]; p_hs[d] = c_hs[d]; p_vs[d] = c_vs[d];
      c_creq[d] = 0; c_eclr[d] = 0;
    end
  endtask

  task automatic apply_reset();
    for (int d = 0; d < 2; d++) begin
      c_s[d] = 0; c_hs[d] = 0; c_vs[d] = 0; c_creq[d] = 0; c_eclr[d] = 0; c_pix[d] = 0;
      drive(d);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin model_reset(d); check(d); end
    chk("rst_wr_addr", 0, 32'(wr_a.wr_addr), 0);
    chk("rst_wr_data", 0, 32'(wr_a.wr_data), 0);
    chk("rst_wr_addr", 1, 32'(wr_b.wr_addr), 0);
    chk("rst_wr_data", 1, 32'(wr_b.wr_data), 0);
    reset = 1'b0;
  endtask

  task automatic pixel(int d, int hold, int gap);
    c_s[d] = 1; c_pix[d] = 2'($urandom);
    tick();
    for (int i = 1; i < hold; i++) begin c_pix[d] = 2'($urandom); tick(); end
    c_s[d] = 0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic vs_pulse(int d);
    c_vs[d] = 1; tick();
    c_vs[d] = 0; tick();
  endtask

  task automatic hs_pulse(int d);
    c_hs[d] = 1; tick();
    c_hs[d] = 0; tick();
  endtask

  task automatic pixels(int d, int n);
    for (int i = 0; i < n; i++) pixel(d, $urandom_range(1, 2), $urandom_range(1, 2));
  endtask

  initial begin
    c_cval[0] = 2'b01;
    c_cval[1] = 2'b10;
    apply_reset();
    for (int i = 0; i < 2*HX*VA + 4; i++) tick();

    // double-buffered frames, one held strobe, one overfull frame
    vs_pulse(0);
    pixel(0, 5, 2);
    pixels(0, HX*VA - 1);
    pixel(0, 1, 1);
    vs_pulse(0);
    c_eclr[0] = 1; tick();
    pixels(0, HX*VA);
    c_vs[0] = 1; c_s[0] = 1; c_pix[0] = 2'($urandom); tick();
    c_vs[0] = 0; c_s[0] = 0; tick();

    // short frame, then err_clr colliding with a new error
    pixels(0, 3*HX - 1);
    vs_pulse(0);
    pixels(0, 5);
    c_vs[0] = 1; c_eclr[0] = 1; tick();
    c_vs[0] = 0; tick();
    c_eclr[0] = 1; tick();

    // clear request mid-frame, restarted during the clear
    pixels(0, 20);
    c_cval[0] = 2'b11;
    c_creq[0] = 1; tick();
    pixels(0, 10);
    c_creq[0] = 1; tick();
    for (int i = 0; i < 300 && m_mode[0] == 0; i++) pixel(0, 1, 1);
    pixels(0, 3);
    vs_pulse(0);
    pixels(0, 10);

    // hsync line advance, single buffer
    vs_pulse(1);
    pixels(1, HX + 2);
    hs_pulse(1);
    pixel(1, 1, 1);
    c_eclr[1] = 1; tick();
    pixels(1, HX - 2);
    c_hs[1] = 1; c_s[1] = 1; c_pix[1] = 2'($urandom); tick();
    c_hs[1] = 0; c_s[1] = 0; tick();
    pixels(1, HX - 1);
    hs_pulse(1);
    hs_pulse(1);
    pixels(1, HX);
    hs_pulse(1);
    pixel(1, 1, 1);
    vs_pulse(1);
    pixels(1, 2);

    // reset in the middle of capture
    apply_reset();
    for (int i = 0; i < 2*HX*VA + 4; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit");
  end
endmodule
